uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter (8N1, 21 clk/bit at 100 MHz) between N_REQ byte sources, e.g. the memory dump path and a status/echo path.
- Round-robin arbitration with packet lock: a granted requester keeps the transmitter until it sends a byte flagged last.
- Sits between the requesters and the UART TX core's start/busy/done interface.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- DATA_W, 8, byte width; fixed by the UART frame.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester byte valid; once high, must stay high until that requester's req_ready bit is high.
- req_data  in  N_REQ*DATA_W  byte for requester k at bits [k*8 +: 8].
- req_last  in  N_REQ  byte ends the packet; sampled with req_data.
- req_ready  out  N_REQ  one-hot accept strobe, 1 cycle per accepted byte.
- tx_start  out  1  1-cycle launch pulse to the TX core.
- tx_data  out  DATA_W  byte to the TX core; stable from tx_start until tx_done.
- tx_busy  in  1  TX core is shifting a frame.
- tx_done  in  1  1-cycle pulse at the end of the stop bit.
- grant_id  out  clog2(N_REQ)  current or last owner.
- arb_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state=IDLE, rr_ptr=0, grant_id=0, req_ready=0, tx_start=0, tx_data=0, arb_busy=0. A reset mid-frame aborts at once; tx_start is 0 in the next cycle. The TX core resets independently.
- FSM states: IDLE, LOAD, SEND, WAIT.
- IDLE:
  - If any req_valid is high, pick the first valid index scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - Register the winner in grant_id and go to LOAD.
- LOAD:
  - req_ready[grant_id] = req_valid[grant_id] (combinational).
  - On valid, capture req_data slice into tx_data and req_last into last_r, then go to SEND.
  - If valid is low (locked packet, requester stalled), stay in LOAD; other requesters stay blocked.
- SEND:
  - If tx_busy=0, assert tx_start for 1 cycle and go to WAIT.
  - If tx_busy=1, hold in SEND.
- WAIT:
  - On tx_done, if last_r=1: rr_ptr = (grant_id+1) mod N_REQ, go to IDLE.
  - On tx_done, if last_r=0: go to LOAD for the same requester.
- Latency:
  - valid seen in IDLE at cycle 0 → ready at cycle 1 → tx_start at cycle 2 (tx_busy=0).
  - Back-to-back bytes of one packet: tx_start spacing = frame time + 3 cycles.
- Simultaneous valids: rotating priority only. Starvation-free provided every packet terminates.
- tx_done outside WAIT is ignored.
- A single-byte packet (last=1 on the first byte) releases after one frame.
- rr_ptr wraps from N_REQ-1 to 0. Arithmetic is modulo N_REQ for non-power-of-two values.
- At most one req_ready bit is high in any cycle. This is asserted in simulation.

Optional Feature:
- Macro: UART_TX_ARB_STATS_EN.
- When defined:
  - Adds output byte_cnt (N_REQ*16) and output pkt_cnt (N_REQ*16).
  - byte_cnt[k] increments on each req_ready[k] pulse.
  - pkt_cnt[k] increments on each accepted byte with last=1.
  - Both are 16-bit, wrap at 0xFFFF to 0, and clear on rst.
- When undefined: the ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Package uart_pkg holds BYTE_W=8, CLKS_PER_BIT=21, FRAME_BITS=10, the arb_state_t enum (IDLE, LOAD, SEND, WAIT), and a function idx_w(n) returning clog2 for n≥2.
- One natural sub-module: rr_picker (combinational).
  - Inputs: req vector, rr_ptr.
  - Outputs: winner index, any_valid.
  - Implemented by rotate, then priority-encode, then un-rotate.

Test Plan:
- Single request: req0 sends 0xA5 with last=1 → tx_start 2 cycles after valid, tx_data=0xA5; serial line shows 0, 1010_0101 LSB-first, 1 at 21 clk/bit; arbiter back in IDLE 1 cycle after tx_done.
- Packet lock: req0 sends 3 bytes {0x11, 0x22, 0x33(last)} while req1 holds 0x44 valid → TX order is 0x11, 0x22, 0x33, 0x44; req_ready[1] stays 0 until 0x33 completes.
- Round-robin fairness: both requesters stream single-byte packets continuously for 8 packets → grant_id sequence 0, 1, 0, 1, ...; each side gets 4.
- Busy hold: tx_busy forced high for 50 cycles in SEND → no tx_start until the cycle after tx_busy falls; tx_data unchanged throughout.
- Stalled locked requester plus reset: req1 drops valid mid-packet → FSM stays in LOAD and req0 stays blocked; rst asserted for 1 cycle → all outputs 0, rr_ptr=0, next grant goes to req0.
- With UART_TX_ARB_STATS_EN: after the lock test, byte_cnt[0]=3, pkt_cnt[0]=1, byte_cnt[1]=1, pkt_cnt[1]=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants, FSM state type and index-width helper for the UART TX arbiter.
package uart_pkg;

    localparam int BYTE_W       = 8;
    localparam int CLKS_PER_BIT = 21;
    localparam int FRAME_BITS   = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        WAIT = 2'd3
    } arb_state_t;

    // Index width for n requesters; never below one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate the request vector so rr_ptr sits at
// bit 0, take the lowest set bit, then rotate the index back.
module rr_picker
    import uart_pkg::*;
#(
    parameter  int N_REQ = 2,
    localparam int IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_rr_ptr,
    output logic [IW-1:0]    o_winner,
    output logic             o_any_valid
);

    logic [N_REQ-1:0] w_rot;
    logic [IW-1:0]    w_pos;
    logic             w_found;
    int               w_src;
    int               w_sum;

    // Rotate requests so that the current priority holder lands at bit 0.
    always_comb begin
        w_rot = '0;
        w_src = 0;
        for (int i = 0; i < N_REQ; i++) begin
            w_src = i + int'(i_rr_ptr);
            if (w_src >= N_REQ) begin
                w_src = w_src - N_REQ;
            end else begin
                w_src = w_src;
            end
            w_rot[i] = i_req[IW'(w_src)];
        end
    end

    // Priority-encode the lowest set bit of the rotated vector.
    always_comb begin
        w_pos   = '0;
        w_found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_rot[i] && !w_found) begin
                w_pos   = IW'(i);
                w_found = 1'b1;
            end else begin
                w_pos   = w_pos;
            end
        end
    end

    // Undo the rotation, modulo N_REQ so non-power-of-two counts wrap correctly.
    always_comb begin
        w_sum = int'(w_pos) + int'(i_rr_ptr);
        if (w_sum >= N_REQ) begin
            w_sum = w_sum - N_REQ;
        end else begin
            w_sum = w_sum;
        end
        o_winner = IW'(w_sum);
    end

    assign o_any_valid = |i_req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART TX core among N_REQ byte sources.
// Optional per-requester byte/packet counters are enabled with UART_TX_ARB_STATS_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int N_REQ  = 2,
    parameter  int DATA_W = BYTE_W,
    localparam int IW     = idx_w(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    tx_start,
    output logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_busy,
    input  logic                    tx_done,
    output logic [IW-1:0]           grant_id,
    output logic                    arb_busy
`ifdef UART_TX_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0]     byte_cnt,
    output logic [N_REQ*16-1:0]     pkt_cnt
`endif
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [IW-1:0]     r_grant_id;
    logic [IW-1:0]     r_rr_ptr;
    logic [IW-1:0]     w_winner;
    logic [IW-1:0]     w_rr_nxt;
    logic              w_any_valid;
    logic              w_sel_valid;
    logic              w_sel_last;
    logic [DATA_W-1:0] w_sel_data;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_last;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .i_req       (req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_winner    (w_winner),
        .o_any_valid (w_any_valid)
    );

    assign w_sel_valid = req_valid[r_grant_id];
    assign w_sel_last  = req_last[r_grant_id];
    assign w_sel_data  = req_data[int'(r_grant_id)*DATA_W +: DATA_W];

    // Priority moves to the requester after the one that just finished its packet.
    always_comb begin
        if (int'(r_grant_id) == N_REQ - 1) begin
            w_rr_nxt = '0;
        end else begin
            w_rr_nxt = r_grant_id + IW'(1'b1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_any_valid ? LOAD : IDLE;
            LOAD:    w_state_nxt = w_sel_valid ? SEND : LOAD;
            SEND:    w_state_nxt = tx_busy ? SEND : WAIT;
            WAIT: begin
                if (tx_done) begin
                    w_state_nxt = r_last ? IDLE : LOAD;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs: ready is a same-cycle handshake, tx_start fires as soon as the core is free.
    always_comb begin
        req_ready = '0;
        tx_start  = 1'b0;
        arb_busy  = 1'b1;
        case (r_state)
            IDLE:    arb_busy = 1'b0;
            LOAD:    req_ready[r_grant_id] = w_sel_valid;
            SEND:    tx_start = ~tx_busy;
            WAIT:    arb_busy = 1'b1;
            default: arb_busy = 1'b0;
        endcase
    end

    // Grant, rotation pointer and captured byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_tx_data  <= '0;
            r_last     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_valid) begin
                        r_grant_id <= w_winner;
                    end
                end
                LOAD: begin
                    if (w_sel_valid) begin
                        r_tx_data <= w_sel_data;
                        r_last    <= w_sel_last;
                    end
                end
                WAIT: begin
                    if (tx_done && r_last) begin
                        r_rr_ptr <= w_rr_nxt;
                    end
                end
                default: r_last <= r_last;
            endcase
        end
    end

    assign tx_data  = r_tx_data;
    assign grant_id = r_grant_id;

`ifdef UART_TX_ARB_STATS_EN
    logic [15:0] r_byte_cnt [N_REQ];
    logic [15:0] r_pkt_cnt  [N_REQ];

    // Per-requester counters; 16-bit natural wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_REQ; k++) begin
                r_byte_cnt[k] <= 16'd0;
                r_pkt_cnt[k]  <= 16'd0;
            end
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (req_ready[k]) begin
                    r_byte_cnt[k] <= r_byte_cnt[k] + 16'd1;
                end
                if (req_ready[k] && req_last[k]) begin
                    r_pkt_cnt[k] <= r_pkt_cnt[k] + 16'd1;
                end
            end
        end
    end

    for (genvar k = 0; k < N_REQ; k++) begin : g_stats
        assign byte_cnt[k*16 +: 16] = r_byte_cnt[k];
        assign pkt_cnt[k*16 +: 16]  = r_pkt_cnt[k];
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural 8N1 TX core and serial receiver.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy;
    logic           tx_done = 1'b0;
    logic [0:0]     grant_id;
    logic           arb_busy;
`ifdef UART_TX_ARB_STATS_EN
    logic [N*16-1:0] byte_cnt;
    logic [N*16-1:0] pkt_cnt;
`endif

    logic       tb_valid [N];
    logic [7:0] tb_data  [N];
    logic       tb_last  [N];
    logic       force_busy;

    logic       core_active = 1'b0;
    logic [9:0] shreg       = 10'h3FF;
    int         clkcnt      = 0;
    int         bitcnt      = 0;
    logic       tx_line;

    typedef struct {
        logic [7:0] data;
        int         gid;
    } exp_t;
    exp_t       exp_q [$];
    logic [7:0] ser_q [$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int k = 0; k < N; k++) begin
            req_valid[k]        = tb_valid[k];
            req_data[k*8 +: 8]  = tb_data[k];
            req_last[k]         = tb_last[k];
        end
    end

    uart_tx_arbiter #(.N_REQ(N), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .grant_id  (grant_id),
        .arb_busy  (arb_busy)
`ifdef UART_TX_ARB_STATS_EN
        ,
        .byte_cnt  (byte_cnt),
        .pkt_cnt   (pkt_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Behavioural TX core: start bit, 8 data bits LSB first, stop bit, CLKS_PER_BIT each.
    always @(posedge clk) begin
        tx_done <= 1'b0;
        if (rst) begin
            core_active <= 1'b0;
            shreg       <= 10'h3FF;
        end else if (!core_active) begin
            if (tx_start) begin
                core_active <= 1'b1;
                shreg       <= {1'b1, tx_data, 1'b0};
                clkcnt      <= 0;
                bitcnt      <= 0;
            end
        end else if (clkcnt == CLKS_PER_BIT - 1) begin
            clkcnt <= 0;
            if (bitcnt == FRAME_BITS - 1) begin
                core_active <= 1'b0;
                tx_done     <= 1'b1;
            end else begin
                bitcnt <= bitcnt + 1;
                shreg  <= shreg >> 1;
            end
        end else begin
            clkcnt <= clkcnt + 1;
        end
    end

    assign tx_line = core_active ? shreg[0] : 1'b1;
    assign tx_busy = core_active | force_busy;

    // Launch monitor: pops the scoreboard on every tx_start, checks one-hot ready each cycle.
    always @(negedge clk) begin
        if (!rst) begin
            check_eq("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
            if (tx_start) begin
                check_eq("start_while_busy", 32'(tx_busy), 32'd0);
                if (exp_q.size() == 0) begin
                    check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("tx_data", 32'(tx_data), 32'(e.data));
                    check_eq("grant_id", 32'(grant_id), 32'(e.gid));
                    ser_q.push_back(e.data);
                end
            end
        end
    end

    // Serial receiver sampling mid-bit.
    initial begin
        logic [7:0] rx;
        forever begin
            @(negedge tx_line);
            repeat (CLKS_PER_BIT / 2) @(posedge clk);
            check_eq("start_bit", 32'(tx_line), 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (CLKS_PER_BIT) @(posedge clk);
                rx[i] = tx_line;
            end
            repeat (CLKS_PER_BIT) @(posedge clk);
            check_eq("stop_bit", 32'(tx_line), 32'd1);
            if (ser_q.size() == 0) begin
                check_eq("ser_underflow", 32'(ser_q.size()), 32'd1);
            end else begin
                check_eq("serial_byte", 32'(rx), 32'(ser_q.pop_front()));
            end
        end
    end

    function automatic void push_exp(input logic [7:0] d, input int g);
        exp_t e;
        e.data = d;
        e.gid  = g;
        exp_q.push_back(e);
    endfunction

    task automatic send_pkt(input int k, input logic [7:0] base, input logic [7:0] step, input int n);
        for (int i = 0; i < n; i++) begin
            automatic int budget = 0;
            tb_data[k]  = base + 8'(i) * step;
            tb_last[k]  = (i == n - 1);
            tb_valid[k] = 1'b1;
            do begin
                @(negedge clk);
                budget++;
            end while (!req_ready[k] && budget < 3000);
            check_eq("accept", 32'(req_ready[k]), 32'd1);
            @(posedge clk);
            #1;
        end
        tb_valid[k] = 1'b0;
        tb_last[k]  = 1'b0;
    endtask

    task automatic wait_quiet();
        automatic int budget = 0;
        while ((arb_busy || core_active || exp_q.size() != 0 || ser_q.size() != 0) && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        check_eq("quiet_timeout", 32'(budget < 5000), 32'd1);
    endtask

    task automatic wait_done();
        automatic int budget = 0;
        while (!tx_done && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        check_eq("done_timeout", 32'(tx_done), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, 32'(req_ready), 32'd0);
        check_eq({tag, "_start"}, 32'(tx_start), 32'd0);
        check_eq({tag, "_data"}, 32'(tx_data), 32'd0);
        check_eq({tag, "_gid"}, 32'(grant_id), 32'd0);
        check_eq({tag, "_busy"}, 32'(arb_busy), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        force_busy = 1'b0;
        for (int k = 0; k < N; k++) begin
            tb_valid[k] = 1'b0;
            tb_data[k]  = 8'h00;
            tb_last[k]  = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #1 rst = 1'b0;

        // Single-byte packet with latency checks.
        push_exp(8'hA5, 0);
        @(posedge clk);
        #1;
        tb_valid[0] = 1'b1;
        tb_data[0]  = 8'hA5;
        tb_last[0]  = 1'b1;
        @(negedge clk);
        check_eq("lat_c0_ready", 32'(req_ready), 32'd0);
        check_eq("lat_c0_busy", 32'(arb_busy), 32'd0);
        @(negedge clk);
        check_eq("lat_c1_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 tb_valid[0] = 1'b0;
        @(negedge clk);
        check_eq("lat_c2_start", 32'(tx_start), 32'd1);
        wait_done();
        check_eq("done_busy", 32'(arb_busy), 32'd1);
        @(negedge clk);
        check_eq("idle_after_done", 32'(arb_busy), 32'd0);
        wait_quiet();

        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;

        // Packet lock: req1 waits behind a 3-byte packet from req0.
        push_exp(8'h11, 0);
        push_exp(8'h22, 0);
        push_exp(8'h33, 0);
        push_exp(8'h44, 1);
        fork
            send_pkt(0, 8'h11, 8'h11, 3);
            send_pkt(1, 8'h44, 8'h00, 1);
        join
        wait_quiet();
`ifdef UART_TX_ARB_STATS_EN
        check_eq("byte_cnt0", 32'(byte_cnt[15:0]), 32'd3);
        check_eq("pkt_cnt0", 32'(pkt_cnt[15:0]), 32'd1);
        check_eq("byte_cnt1", 32'(byte_cnt[31:16]), 32'd1);
        check_eq("pkt_cnt1", 32'(pkt_cnt[31:16]), 32'd1);
`endif

        // Fairness: both stream single-byte packets, grants must alternate.
        for (int i = 0; i < 4; i++) begin
            push_exp(8'h60 + 8'(i), 0);
            push_exp(8'h70 + 8'(i), 1);
        end
        fork
            begin
                for (int i = 0; i < 4; i++) send_pkt(0, 8'h60 + 8'(i), 8'h00, 1);
            end
            begin
                for (int j = 0; j < 4; j++) send_pkt(1, 8'h70 + 8'(j), 8'h00, 1);
            end
        join
        wait_quiet();

        // Busy hold in SEND.
        force_busy = 1'b1;
        push_exp(8'h5A, 0);
        fork
            send_pkt(0, 8'h5A, 8'h00, 1);
        join_none
        repeat (10) @(negedge clk);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check_eq("hold_start", 32'(tx_start), 32'd0);
            check_eq("hold_data", 32'(tx_data), 32'h5A);
        end
        @(posedge clk);
        #1 force_busy = 1'b0;
        @(negedge clk);
        check_eq("release_start", 32'(tx_start), 32'd1);
        wait_quiet();

        // Stalled locked requester, then reset.
        push_exp(8'h91, 1);
        @(posedge clk);
        #1;
        tb_valid[1] = 1'b1;
        tb_data[1]  = 8'h91;
        tb_last[1]  = 1'b0;
        begin
            automatic int budget = 0;
            do begin
                @(negedge clk);
                budget++;
            end while (!req_ready[1] && budget < 100);
            check_eq("stall_accept", 32'(req_ready[1]), 32'd1);
        end
        @(posedge clk);
        #1;
        tb_valid[1] = 1'b0;
        tb_valid[0] = 1'b1;
        tb_data[0]  = 8'hB0;
        tb_last[0]  = 1'b1;
        wait_done();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("stall_ready", 32'(req_ready), 32'd0);
            check_eq("stall_busy", 32'(arb_busy), 32'd1);
            check_eq("stall_gid", 32'(grant_id), 32'd1);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        push_exp(8'hB0, 0);
        push_exp(8'hC1, 1);
        fork
            send_pkt(0, 8'hB0, 8'h00, 1);
            send_pkt(1, 8'hC1, 8'h00, 1);
        join
        wait_quiet();
        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
